// File: rtl/csa_accum.sv
// Frame accumulator holding a carry-save sum of unsigned beats (add or subtract),
// resolved CHUNK bits per cycle into a binary result with beat count and parity.
module csa_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sub,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+CNT_W-1:0]   out_sum,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_ovf,
    output logic                     out_parity
);
    localparam int ACC_W = WIDTH + CNT_W;
    localparam int NCH   = (ACC_W + CHUNK - 1) / CHUNK;
    localparam int PAD_W = NCH * CHUNK;
    localparam int IDX_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [PAD_W-1:0]   sum_q;
    logic               par_q;

    logic               accept;
    logic [ACC_W-1:0]   x, maj;
    logic [PAD_W-1:0]   s_pad, c_pad;
    logic [CHUNK-1:0]   s_ch, c_ch;
    logic [CHUNK:0]     ch_sum;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign accept    = in_valid & in_ready;

    // Subtraction is x = ~operand with the +1 injected through the freed C[0] slot.
    assign x   = in_sub ? ~{{CNT_W{1'b0}}, in_data} : {{CNT_W{1'b0}}, in_data};
    assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

    assign s_pad = PAD_W'(s_q);
    assign c_pad = PAD_W'(c_q);

    always_comb begin
        s_ch = '0;
        c_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                s_ch = s_pad[k*CHUNK +: CHUNK];
                c_ch = c_pad[k*CHUNK +: CHUNK];
            end
        end
        ch_sum = {1'b0, s_ch} + {1'b0, c_ch} + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && in_last) state_d = RESOLVE;
            RESOLVE: if (idx_q == IDX_W'(NCH)) state_d = OUT;
            OUT:     if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        s_q <= s_q ^ c_q ^ x;
                        c_q <= {maj[ACC_W-2:0], in_sub};
                        if (cnt_q == {CNT_W{1'b1}}) ovf_q <= 1'b1;
                        else                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESOLVE: begin
                    // One extra cycle after the last chunk registers the parity.
                    if (idx_q != IDX_W'(NCH)) begin
                        for (int k = 0; k < NCH; k++) begin
                            if (idx_q == IDX_W'(k)) sum_q[k*CHUNK +: CHUNK] <= ch_sum[CHUNK-1:0];
                        end
                        carry_q <= ch_sum[CHUNK];
                        idx_q   <= idx_q + 1'b1;
                    end else begin
                        par_q <= ^sum_q[ACC_W-1:0];
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        s_q     <= '0;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum    = out_valid ? sum_q[ACC_W-1:0] : '0;
    assign out_beats  = out_valid ? cnt_q : '0;
    assign out_ovf    = out_valid & ovf_q;
    assign out_parity = out_valid & par_q;
endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum at WIDTH=8, CNT_W=4, CHUNK=4 (12-bit result, 3 chunks).
module tb_csa_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub, in_last;
    logic [7:0]  in_data;
    logic        out_valid, out_ready;
    logic [11:0] out_sum;
    logic [3:0]  out_beats;
    logic        out_ovf, out_parity;

    int n_checks = 0;
    int n_fail   = 0;

    csa_accum #(.WIDTH(8), .CNT_W(4), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_beats(out_beats), .out_ovf(out_ovf), .out_parity(out_parity)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  d [4];
        logic [3:0]  sub;
        logic [11:0] sum;
        logic [3:0]  beats;
        logic        ovf;
        logic        par;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic sub, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        check("in_ready_before_beat", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sub   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called 1 time unit after the edge that accepted the last beat.
    task automatic expect_result(input string name, input logic [11:0] sum, input logic [3:0] beats,
                                 input logic ovf, input logic par, input logic keep_ready);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 4);
        check({name, "_sum"}, out_sum, sum);
        check({name, "_beats"}, out_beats, beats);
        check({name, "_ovf"}, out_ovf, ovf);
        check({name, "_parity"}, out_parity, par);
        check({name, "_in_ready_in_out"}, in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_ready) out_ready = 1'b0;
        check({name, "_valid_after_hs"}, out_valid, 0);
        check({name, "_ready_after_hs"}, in_ready, 1);
        check({name, "_sum_gated"}, out_sum, 0);
    endtask

    initial begin
        logic [11:0] held_sum;
        vecs[0].n = 3; vecs[0].d = '{8'hFF, 8'hFF, 8'hFF, 8'h00}; vecs[0].sub = 4'b0000;
        vecs[0].sum = 12'h2FD; vecs[0].beats = 4'd3; vecs[0].ovf = 1'b0; vecs[0].par = 1'b0;
        vecs[1].n = 2; vecs[1].d = '{8'h10, 8'h20, 8'h00, 8'h00}; vecs[1].sub = 4'b0010;
        vecs[1].sum = 12'hFF0; vecs[1].beats = 4'd2; vecs[1].ovf = 1'b0; vecs[1].par = 1'b0;
        vecs[2].n = 1; vecs[2].d = '{8'h01, 8'h00, 8'h00, 8'h00}; vecs[2].sub = 4'b0001;
        vecs[2].sum = 12'hFFF; vecs[2].beats = 4'd1; vecs[2].ovf = 1'b0; vecs[2].par = 1'b0;
        vecs[3].n = 1; vecs[3].d = '{8'h07, 8'h00, 8'h00, 8'h00}; vecs[3].sub = 4'b0000;
        vecs[3].sum = 12'h007; vecs[3].beats = 4'd1; vecs[3].ovf = 1'b0; vecs[3].par = 1'b1;
        vecs[4].n = 3; vecs[4].d = '{8'h80, 8'h80, 8'h01, 8'h00}; vecs[4].sub = 4'b0100;
        vecs[4].sum = 12'h0FF; vecs[4].beats = 4'd3; vecs[4].ovf = 1'b0; vecs[4].par = 1'b0;
        vecs[5].n = 4; vecs[5].d = '{8'hFF, 8'hFF, 8'h03, 8'h01}; vecs[5].sub = 4'b1010;
        vecs[5].sum = 12'h002; vecs[5].beats = 4'd4; vecs[5].ovf = 1'b0; vecs[5].par = 1'b1;

        // Reset with a beat offered: nothing may be absorbed.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h07; in_sub = 1'b0; in_last = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_beats", out_beats, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_result_from_reset_beat", out_valid, 0);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < vecs[i].n; b++)
                send_beat(vecs[i].d[b], vecs[i].sub[b], b == vecs[i].n - 1);
            expect_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].beats, vecs[i].ovf, vecs[i].par, 1'b0);
        end

        // 17 beats of 1: count saturates at 15, overflow sticks.
        for (int b = 0; b < 17; b++) send_beat(8'h01, 1'b0, b == 16);
        expect_result("sat17", 12'h011, 4'd15, 1'b1, 1'b0, 1'b0);

        // Backpressure in OUT while beats are offered.
        send_beat(8'h21, 1'b0, 1'b0);
        send_beat(8'h12, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid", out_valid, 1);
        check("bp_sum", out_sum, 12'h033);
        held_sum = out_sum;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1; in_sub = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", out_sum, held_sum);
            check("bp_hold_beats", out_beats, 2);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_released", out_valid, 0);
        send_beat(8'h05, 1'b0, 1'b1);
        expect_result("after_bp", 12'h005, 4'd1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of RESOLVE discards the frame.
        send_beat(8'h33, 1'b0, 1'b0);
        send_beat(8'h44, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_result", out_valid, 0);
        send_beat(8'h05, 1'b0, 1'b1);
        expect_result("post_reset", 12'h005, 4'd1, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with the consumer always ready.
        @(negedge clk);
        out_ready = 1'b1;
        send_beat(8'h01, 1'b1, 1'b1);
        expect_result("b2b_a", 12'hFFF, 4'd1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h02, 1'b0, 1'b1);
        expect_result("b2b_b", 12'h002, 4'd1, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
